// File: rtl/inst_enc_r_pkg.sv
// Shared constants for the R-type instruction encoder: internal INST_* codes,
// MIPS32 major opcodes and funct values, plus a field-packing helper.
package inst_enc_r_pkg;

  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_SLL     = 8'h01;
  localparam logic [7:0] INST_SRL     = 8'h02;
  localparam logic [7:0] INST_SRA     = 8'h03;
  localparam logic [7:0] INST_SLLV    = 8'h04;
  localparam logic [7:0] INST_SRLV    = 8'h05;
  localparam logic [7:0] INST_SRAV    = 8'h06;
  localparam logic [7:0] INST_JR      = 8'h07;
  localparam logic [7:0] INST_JALR    = 8'h08;
  localparam logic [7:0] INST_MOVZ    = 8'h09;
  localparam logic [7:0] INST_MOVN    = 8'h0a;
  localparam logic [7:0] INST_SYSCALL = 8'h0b;
  localparam logic [7:0] INST_BREAK   = 8'h0c;
  localparam logic [7:0] INST_MFHI    = 8'h0d;
  localparam logic [7:0] INST_MTHI    = 8'h0e;
  localparam logic [7:0] INST_MFLO    = 8'h0f;
  localparam logic [7:0] INST_MTLO    = 8'h10;
  localparam logic [7:0] INST_MULT    = 8'h11;
  localparam logic [7:0] INST_MULTU   = 8'h12;
  localparam logic [7:0] INST_DIV     = 8'h13;
  localparam logic [7:0] INST_DIVU    = 8'h14;
  localparam logic [7:0] INST_ADD     = 8'h15;
  localparam logic [7:0] INST_ADDU    = 8'h16;
  localparam logic [7:0] INST_SUB     = 8'h17;
  localparam logic [7:0] INST_SUBU    = 8'h18;
  localparam logic [7:0] INST_AND     = 8'h19;
  localparam logic [7:0] INST_OR      = 8'h1a;
  localparam logic [7:0] INST_XOR     = 8'h1b;
  localparam logic [7:0] INST_NOR     = 8'h1c;
  localparam logic [7:0] INST_SLT     = 8'h1d;
  localparam logic [7:0] INST_SLTU    = 8'h1e;
  localparam logic [7:0] INST_MADD    = 8'h1f;
  localparam logic [7:0] INST_MADDU   = 8'h20;
  localparam logic [7:0] INST_MUL     = 8'h21;
  localparam logic [7:0] INST_MSUB    = 8'h22;
  localparam logic [7:0] INST_MSUBU   = 8'h23;
  localparam logic [7:0] INST_CLZ     = 8'h24;
  localparam logic [7:0] INST_CLO     = 8'h25;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1c;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MOVZ    = 6'h0a;
  localparam logic [5:0] FN_MOVN    = 6'h0b;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  localparam logic [5:0] FN2_MADD   = 6'h00;
  localparam logic [5:0] FN2_MADDU  = 6'h01;
  localparam logic [5:0] FN2_MUL    = 6'h02;
  localparam logic [5:0] FN2_MSUB   = 6'h04;
  localparam logic [5:0] FN2_MSUBU  = 6'h05;
  localparam logic [5:0] FN2_CLZ    = 6'h20;
  localparam logic [5:0] FN2_CLO    = 6'h21;

  function automatic logic [31:0] r_word(
    input logic [5:0] op,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] sa,
    input logic [5:0] fn
  );
    return {op, rs, rt, rd, sa, fn};
  endfunction

endpackage

// File: rtl/inst_enc_r_fifo.sv
// DEPTH x W synchronous FIFO with a registered head word; the head register is
// refilled on the edge that pops or first fills it, so rd_data never depends on inputs.
module inst_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  head_reg;
  logic          wr, rd;

  assign full        = (count_reg == DEPTH_C);
  assign empty       = (count_reg == '0);
  assign wr          = wr_en && !full;
  assign rd          = rd_en && !empty;
  assign rd_ptr_next = rd_ptr_reg + 1'b1;
  assign count       = count_reg;
  assign rd_data     = head_reg;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd) rd_ptr_reg <= rd_ptr_next;
      case ({wr, rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The entry behind the head is either already stored or is the word arriving now.
      if (wr && (empty || (rd && count_reg == ONE_C)))
        head_reg <= wr_data;
      else if (rd && count_reg > ONE_C)
        head_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/inst_enc_r.sv
// Registered R-type instruction encoder feeding a small output FIFO.
// Optional SPECIAL2 encoding is compiled in when INST_ENC_SPECIAL2_EN is defined.
module inst_enc_r
  import inst_enc_r_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       inst,
  input  logic [4:0]       reg_s,
  input  logic [4:0]       reg_t,
  input  logic [4:0]       reg_d,
  input  logic [4:0]       shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_code,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [4:0] Z = 5'd0;

  logic [31:0]   enc_word;
  logic          enc_ok;
  logic          accept, push;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          err_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (inst)
      INST_SLL:     enc_word = r_word(OP_SPECIAL, Z, reg_t, reg_d, shift, FN_SLL);
      INST_SRL:     enc_word = r_word(OP_SPECIAL, Z, reg_t, reg_d, shift, FN_SRL);
      INST_SRA:     enc_word = r_word(OP_SPECIAL, Z, reg_t, reg_d, shift, FN_SRA);
      INST_SLLV:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SLLV);
      INST_SRLV:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SRLV);
      INST_SRAV:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SRAV);
      INST_JR:      enc_word = r_word(OP_SPECIAL, reg_s, Z, Z, Z, FN_JR);
      INST_JALR:    enc_word = r_word(OP_SPECIAL, reg_s, Z, reg_d, Z, FN_JALR);
      INST_MOVZ:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_MOVZ);
      INST_MOVN:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_MOVN);
      INST_SYSCALL: enc_word = r_word(OP_SPECIAL, Z, Z, Z, Z, FN_SYSCALL);
      INST_BREAK:   enc_word = r_word(OP_SPECIAL, Z, Z, Z, Z, FN_BREAK);
      INST_MFHI:    enc_word = r_word(OP_SPECIAL, Z, Z, reg_d, Z, FN_MFHI);
      INST_MFLO:    enc_word = r_word(OP_SPECIAL, Z, Z, reg_d, Z, FN_MFLO);
      INST_MTHI:    enc_word = r_word(OP_SPECIAL, reg_s, Z, Z, Z, FN_MTHI);
      INST_MTLO:    enc_word = r_word(OP_SPECIAL, reg_s, Z, Z, Z, FN_MTLO);
      INST_MULT:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, Z, Z, FN_MULT);
      INST_MULTU:   enc_word = r_word(OP_SPECIAL, reg_s, reg_t, Z, Z, FN_MULTU);
      INST_DIV:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, Z, Z, FN_DIV);
      INST_DIVU:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, Z, Z, FN_DIVU);
      INST_ADD:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_ADD);
      INST_ADDU:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_ADDU);
      INST_SUB:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SUB);
      INST_SUBU:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SUBU);
      INST_AND:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_AND);
      INST_OR:      enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_OR);
      INST_XOR:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_XOR);
      INST_NOR:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_NOR);
      INST_SLT:     enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SLT);
      INST_SLTU:    enc_word = r_word(OP_SPECIAL, reg_s, reg_t, reg_d, Z, FN_SLTU);
`ifdef INST_ENC_SPECIAL2_EN
      INST_MADD:    enc_word = r_word(OP_SPECIAL2, reg_s, reg_t, Z, Z, FN2_MADD);
      INST_MADDU:   enc_word = r_word(OP_SPECIAL2, reg_s, reg_t, Z, Z, FN2_MADDU);
      INST_MSUB:    enc_word = r_word(OP_SPECIAL2, reg_s, reg_t, Z, Z, FN2_MSUB);
      INST_MSUBU:   enc_word = r_word(OP_SPECIAL2, reg_s, reg_t, Z, Z, FN2_MSUBU);
      INST_MUL:     enc_word = r_word(OP_SPECIAL2, reg_s, reg_t, reg_d, Z, FN2_MUL);
      // CLZ/CLO architecturally require rt == rd.
      INST_CLZ:     enc_word = r_word(OP_SPECIAL2, reg_s, reg_d, reg_d, Z, FN2_CLZ);
      INST_CLO:     enc_word = r_word(OP_SPECIAL2, reg_s, reg_d, reg_d, Z, FN2_CLO);
`endif
      default:      enc_ok = 1'b0;
    endcase
  end

  assign in_ready = (fifo_count < DEPTH_C);
  assign accept   = in_valid && !fifo_full;
  assign push     = accept && enc_ok;

  inst_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (enc_word),
    .rd_en   (out_ready),
    .rd_data (inst_code),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      err_reg <= accept && !enc_ok;
      if (accept && !enc_ok && err_cnt_reg != '1)
        err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_inst_enc_r.sv
// Randomized self-checking bench for inst_enc_r against a field-mask reference model.
// Follows INST_ENC_SPECIAL2_EN the same way the design does.
module tb_inst_enc_r;
  import inst_enc_r_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0] inst;
  logic [4:0] reg_s, reg_t, reg_d, shift;
  logic [31:0] inst_code;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  inst_enc_r #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .reg_s(reg_s), .reg_t(reg_t), .reg_d(reg_d), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .inst_code(inst_code),
    .err(err), .err_cnt(err_cnt)
  );

  int total = 0;
  int passed = 0;

  logic [31:0] q[$];
  bit          m_err;
  int          m_cnt;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    else passed++;
  endtask

  // Reference: which fields each op keeps, then assemble with shifts.
  function automatic void model_enc(input logic [7:0] c, input logic [4:0] s, t, d, a,
                                    output bit ok, output logic [31:0] w);
    bit [3:0] keep = 4'b0000;   // {rs, rt, rd, sa}
    bit rt_from_rd = 0;
    int op = 0, fn = 0;
    ok = 1;
    case (c)
      INST_SLL:  begin fn = 'h00; keep = 4'b0111; end
      INST_SRL:  begin fn = 'h02; keep = 4'b0111; end
      INST_SRA:  begin fn = 'h03; keep = 4'b0111; end
      INST_SLLV: begin fn = 'h04; keep = 4'b1110; end
      INST_SRLV: begin fn = 'h06; keep = 4'b1110; end
      INST_SRAV: begin fn = 'h07; keep = 4'b1110; end
      INST_JR:   begin fn = 'h08; keep = 4'b1000; end
      INST_JALR: begin fn = 'h09; keep = 4'b1010; end
      INST_MOVZ: begin fn = 'h0a; keep = 4'b1110; end
      INST_MOVN: begin fn = 'h0b; keep = 4'b1110; end
      INST_SYSCALL: fn = 'h0c;
      INST_BREAK:   fn = 'h0d;
      INST_MFHI:  begin fn = 'h10; keep = 4'b0010; end
      INST_MTHI:  begin fn = 'h11; keep = 4'b1000; end
      INST_MFLO:  begin fn = 'h12; keep = 4'b0010; end
      INST_MTLO:  begin fn = 'h13; keep = 4'b1000; end
      INST_MULT:  begin fn = 'h18; keep = 4'b1100; end
      INST_MULTU: begin fn = 'h19; keep = 4'b1100; end
      INST_DIV:   begin fn = 'h1a; keep = 4'b1100; end
      INST_DIVU:  begin fn = 'h1b; keep = 4'b1100; end
      INST_ADD:   begin fn = 'h20; keep = 4'b1110; end
      INST_ADDU:  begin fn = 'h21; keep = 4'b1110; end
      INST_SUB:   begin fn = 'h22; keep = 4'b1110; end
      INST_SUBU:  begin fn = 'h23; keep = 4'b1110; end
      INST_AND:   begin fn = 'h24; keep = 4'b1110; end
      INST_OR:    begin fn = 'h25; keep = 4'b1110; end
      INST_XOR:   begin fn = 'h26; keep = 4'b1110; end
      INST_NOR:   begin fn = 'h27; keep = 4'b1110; end
      INST_SLT:   begin fn = 'h2a; keep = 4'b1110; end
      INST_SLTU:  begin fn = 'h2b; keep = 4'b1110; end
`ifdef INST_ENC_SPECIAL2_EN
      INST_MADD:  begin op = 'h1c; fn = 'h00; keep = 4'b1100; end
      INST_MADDU: begin op = 'h1c; fn = 'h01; keep = 4'b1100; end
      INST_MUL:   begin op = 'h1c; fn = 'h02; keep = 4'b1110; end
      INST_MSUB:  begin op = 'h1c; fn = 'h04; keep = 4'b1100; end
      INST_MSUBU: begin op = 'h1c; fn = 'h05; keep = 4'b1100; end
      INST_CLZ:   begin op = 'h1c; fn = 'h20; keep = 4'b1010; rt_from_rd = 1; end
      INST_CLO:   begin op = 'h1c; fn = 'h21; keep = 4'b1010; rt_from_rd = 1; end
`endif
      default: ok = 0;
    endcase
    w = 32'(op) * 32'h0400_0000 + 32'(fn)
      + (keep[3] ? 32'(s) * 32'h0020_0000 : 32'd0)
      + (rt_from_rd ? 32'(d) * 32'h0001_0000 : (keep[2] ? 32'(t) * 32'h0001_0000 : 32'd0))
      + (keep[1] ? 32'(d) * 32'h0000_0800 : 32'd0)
      + (keep[0] ? 32'(a) * 32'h0000_0040 : 32'd0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("inst_code", inst_code, q[0]);
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  // Called at a negedge: check, drive, predict the coming edge, advance one cycle.
  task automatic cycle(input bit v, input logic [7:0] c, input logic [4:0] s, t, d, a,
                       input bit ordy);
    bit acc, pop, ok;
    logic [31:0] w;
    check_state();
    in_valid = v; inst = c; reg_s = s; reg_t = t; reg_d = d; shift = a; out_ready = ordy;
    acc = v && (q.size() < DEPTH);
    pop = (q.size() > 0) && ordy;
    model_enc(c, s, t, d, a, ok, w);
    if (pop) void'(q.pop_front());
    if (acc && ok) q.push_back(w);
    m_err = acc && !ok;
    if (m_err && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle(0, INST_INVALID, 0, 0, 0, 0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++) idle(1);
    idle(1);
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [7:0] c, input logic [4:0] s, t, d, a,
                          input logic [31:0] exp_w, input bit exp_ok);
    drain();
    cycle(1, c, s, t, d, a, 0);
    if (exp_ok) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_word"}, inst_code, exp_w);
    end else begin
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_nowrite"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; inst = 0; reg_s = 0; reg_t = 0; reg_d = 0; shift = 0;
    out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inst_code", inst_code, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    directed("addu", INST_ADDU, 1, 2, 3, 5, 32'h0022_1821, 1);
    directed("sll",  INST_SLL, 7, 1, 2, 4, 32'h0001_1100, 1);
    directed("jr",   INST_JR, 31, 9, 9, 0, 32'h03E0_0008, 1);
`ifdef INST_ENC_SPECIAL2_EN
    directed("mul",  INST_MUL, 4, 5, 6, 0, 32'h7085_3002, 1);
    directed("clz",  INST_CLZ, 3, 0, 9, 0, 32'h7069_4820, 1);
`else
    directed("clz",  INST_CLZ, 3, 0, 9, 0, 32'h7069_4820, 0);
    chk("clz_err_cnt", 32'(err_cnt), 32'd1);
    directed("mul",  INST_MUL, 4, 5, 6, 0, 32'h7085_3002, 0);
`endif

    // Backpressure: five pushes into a four-deep FIFO, then drain.
    drain();
    for (int i = 0; i < 4; i++) cycle(1, INST_ADDU, 5'(i), 5'(i + 1), 5'(i + 2), 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1, INST_ADDU, 4, 5, 6, 0, 0);
    chk("fifth_blocked", 32'(last_acc), 32'd0);
    last_acc = 0;
    for (int i = 0; i < 10 && !last_acc; i++) cycle(1, INST_ADDU, 4, 5, 6, 0, 1);
    chk("fifth_accepted", 32'(last_acc), 32'd1);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) cycle(1, INST_INVALID, 5'($urandom), 5'($urandom),
                                        5'($urandom), 5'($urandom), 1);
    idle(1);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(1, 37)) : 8'($urandom);
      cycle($urandom_range(0, 9) < 7, c, 5'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), $urandom_range(0, 9) < 6);
    end

    // Mid-cycle asynchronous reset with a full-ish FIFO and a pending err.
    drain();
    for (int i = 0; i < 3; i++) cycle(1, INST_OR, 5'(i), 5'(i), 5'(i), 0, 0);
    cycle(1, INST_INVALID, 0, 0, 0, 0, 0);
    chk("pre_rst_err", 32'(err), 32'd1);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cycle(1, INST_XOR, 10, 11, 12, 13, 0);
    chk("post_rst_head", inst_code, 32'h014B_6026);
    idle(0);
    chk("post_rst_alone", 32'(in_ready), 32'd1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
